// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the master state encoding.
package axi_lite_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    READ,
    RDATA,
    RESP
  } master_state_e;

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite master: turns one user command at a time into a single AXI-Lite
// read or write and reports the slave's response with a one-cycle pulse.
// Every output is a flop; the next-state process computes their next values.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // user command / response
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  // write address channel
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  // write data channel
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  // write response channel
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp,
  // read address channel
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  // read data channel
  input  logic [DATA_W-1:0]   rdata,
  input  logic                rvalid,
  output logic                rready,
  input  logic [1:0]          rresp
);

  localparam int STRB_W = DATA_W / 8;

  master_state_e state, state_nxt;

  logic              cmd_ready_nxt;
  logic              awvalid_nxt, wvalid_nxt, bready_nxt;
  logic              arvalid_nxt, rready_nxt, rsp_valid_nxt;
  logic [ADDR_W-1:0] awaddr_nxt, araddr_nxt;
  logic [DATA_W-1:0] wdata_nxt, rsp_rdata_nxt;
  logic [STRB_W-1:0] wstrb_nxt;
  logic [1:0]        rsp_resp_nxt;

  // State register; reset drops any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_nxt     = state;
    awvalid_nxt   = awvalid;
    wvalid_nxt    = wvalid;
    bready_nxt    = bready;
    arvalid_nxt   = arvalid;
    rready_nxt    = rready;
    rsp_valid_nxt = 1'b0;
    awaddr_nxt    = awaddr;
    araddr_nxt    = araddr;
    wdata_nxt     = wdata;
    wstrb_nxt     = wstrb;
    rsp_rdata_nxt = rsp_rdata;
    rsp_resp_nxt  = rsp_resp;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_write) begin
            awaddr_nxt  = cmd_addr;
            wdata_nxt   = cmd_wdata;
            wstrb_nxt   = cmd_wstrb;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
            state_nxt   = WRITE;
          end else begin
            araddr_nxt  = cmd_addr;
            arvalid_nxt = 1'b1;
            state_nxt   = READ;
          end
        end
      end
      WRITE: begin
        // A dropped valid means its handshake already happened; each channel
        // retires on its own and the two may finish in any order.
        if (awvalid && awready) awvalid_nxt = 1'b0;
        if (wvalid && wready)   wvalid_nxt  = 1'b0;
        if ((!awvalid || awready) && (!wvalid || wready)) begin
          bready_nxt = 1'b1;
          state_nxt  = WRESP;
        end
      end
      WRESP: begin
        if (bvalid) begin
          bready_nxt    = 1'b0;
          rsp_rdata_nxt = '0;
          rsp_resp_nxt  = bresp;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RESP;
        end
      end
      READ: begin
        if (arready) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = RDATA;
        end
      end
      RDATA: begin
        if (rvalid) begin
          rready_nxt    = 1'b0;
          rsp_rdata_nxt = rdata;
          rsp_resp_nxt  = rresp;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    cmd_ready_nxt = (state_nxt == IDLE);
  end

  // Output registers; all clear to the idle bus on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready <= 1'b1;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      rsp_valid <= 1'b0;
      awaddr    <= '0;
      araddr    <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      rsp_rdata <= '0;
      rsp_resp  <= OKAY;
    end else begin
      cmd_ready <= cmd_ready_nxt;
      awvalid   <= awvalid_nxt;
      wvalid    <= wvalid_nxt;
      bready    <= bready_nxt;
      arvalid   <= arvalid_nxt;
      rready    <= rready_nxt;
      rsp_valid <= rsp_valid_nxt;
      awaddr    <= awaddr_nxt;
      araddr    <= araddr_nxt;
      wdata     <= wdata_nxt;
      wstrb     <= wstrb_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_resp  <= rsp_resp_nxt;
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a small AXI-Lite slave with stall/response knobs,
// a transaction-level expectation model and a per-cycle compare process.
module tb_axi_lite_master;
  import axi_lite_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;

  always #5 clk = ~clk;

  axi_lite_master #(.ADDR_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready), .rresp(rresp)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- companion slave ----------------
  int          aw_stall = 0, w_stall = 0, ar_stall = 0;
  bit          b_block = 1'b0;
  logic [1:0]  bresp_code = OKAY, rresp_code = OKAY;
  int          aw_cnt, w_cnt, ar_cnt;
  logic        aw_got, w_got;
  logic [3:0]  s_addr, s_strb, sel_addr, sel_strb;
  logic [31:0] s_data, sel_data;
  logic [31:0] smem [4];
  logic        wr_done;

  assign awready  = (aw_cnt >= aw_stall);
  assign wready   = (w_cnt >= w_stall);
  assign arready  = (ar_cnt >= ar_stall);
  assign sel_addr = (awvalid && awready) ? awaddr : s_addr;
  assign sel_data = (wvalid && wready) ? wdata : s_data;
  assign sel_strb = (wvalid && wready) ? wstrb : s_strb;
  assign wr_done  = (aw_got || (awvalid && awready)) && (w_got || (wvalid && wready));

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      s_addr <= '0; s_data <= '0; s_strb <= '0;
      bvalid <= 1'b0; bresp <= OKAY;
      rvalid <= 1'b0; rdata <= '0; rresp <= OKAY;
    end else begin
      if (awvalid && !awready) aw_cnt <= aw_cnt + 1; else if (awvalid) aw_cnt <= 0;
      if (wvalid && !wready)   w_cnt  <= w_cnt + 1;  else if (wvalid)  w_cnt  <= 0;
      if (arvalid && !arready) ar_cnt <= ar_cnt + 1; else if (arvalid) ar_cnt <= 0;
      if (awvalid && awready) begin aw_got <= 1'b1; s_addr <= awaddr; end
      if (wvalid && wready) begin w_got <= 1'b1; s_data <= wdata; s_strb <= wstrb; end
      if (wr_done) begin
        for (int i = 0; i < 4; i++)
          if (sel_strb[i]) smem[sel_addr[3:2]][8*i +: 8] <= sel_data[8*i +: 8];
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        if (!b_block) begin bvalid <= 1'b1; bresp <= bresp_code; end
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
      if (arvalid && arready) begin
        rvalid <= 1'b1; rdata <= smem[araddr[3:2]]; rresp <= rresp_code;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  // ---------------- transaction model ----------------
  logic [31:0] mmem [4];
  logic [31:0] exp_rdata [$];
  logic [1:0]  exp_resp  [$];

  task automatic push_expect(input logic wr, input logic [3:0] a, input logic [31:0] d,
                             input logic [3:0] s);
    if (wr) begin
      for (int i = 0; i < 4; i++)
        if (s[i]) mmem[a[3:2]][8*i +: 8] = d[8*i +: 8];
      exp_rdata.push_back(32'h0);
      exp_resp.push_back(bresp_code);
    end else begin
      exp_rdata.push_back(mmem[a[3:2]]);
      exp_resp.push_back(rresp_code);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  int          exp_rd = 0, rsp_seen = 0, aw_hi = 0, w_hi = 0;
  bit          busy = 0, first_chk = 0, first_wr = 0, aw_hs = 0, w_hs = 0, ar_hs = 0;
  logic [3:0]  cur_addr, cur_strb;
  logic [31:0] cur_data;
  logic        p_awvalid = 0, p_awready = 0, p_wvalid = 0, p_wready = 0;
  logic        p_arvalid = 0, p_arready = 0, p_bready = 0, p_bvalid = 0;
  logic        p_rready = 0, p_rvalid = 0;
  logic [3:0]  p_awaddr, p_araddr, p_wstrb;
  logic [31:0] p_wdata;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_rd = exp_rdata.size();
        busy = 0; first_chk = 0; aw_hs = 0; w_hs = 0; ar_hs = 0;
        p_awvalid = 0; p_wvalid = 0; p_arvalid = 0; p_bready = 0; p_rready = 0;
      end else begin
        check("cmd_ready", cmd_ready, !busy);
        if (!busy)
          check("idle_quiet", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 6'b0);
        if (first_chk) begin
          check("aw_start", awvalid, first_wr);
          check("w_start", wvalid, first_wr);
          check("ar_start", arvalid, !first_wr);
          first_chk = 0;
        end
        if (p_awvalid && !p_awready) check("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
        if (p_wvalid && !p_wready)
          check("w_hold", {wvalid, wstrb, wdata}, {1'b1, p_wstrb, p_wdata});
        if (p_arvalid && !p_arready) check("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
        if (p_bready && !p_bvalid) check("b_hold", bready, 1'b1);
        if (p_rready && !p_rvalid) check("r_hold", rready, 1'b1);
        if (awvalid) check("awaddr", awaddr, cur_addr);
        if (wvalid)  check("wbeat", {wstrb, wdata}, {cur_strb, cur_data});
        if (arvalid) check("araddr", araddr, cur_addr);
        if (awvalid && !p_awvalid) check("aw_once", aw_hs, 1'b0);
        if (wvalid && !p_wvalid)   check("w_once", w_hs, 1'b0);
        if (arvalid && !p_arvalid) check("ar_once", ar_hs, 1'b0);
        if (rsp_valid) begin
          rsp_seen++;
          if (exp_rd < exp_rdata.size()) begin
            check("rsp_rdata", rsp_rdata, exp_rdata[exp_rd]);
            check("rsp_resp", rsp_resp, exp_resp[exp_rd]);
            exp_rd++;
          end else begin
            check("rsp_unexpected", rsp_valid, 1'b0);
          end
          busy = 0;
        end
        aw_hi += int'(awvalid);
        w_hi  += int'(wvalid);
        if (awvalid && awready) aw_hs = 1;
        if (wvalid && wready)   w_hs  = 1;
        if (arvalid && arready) ar_hs = 1;
        if (cmd_valid && cmd_ready) begin
          busy = 1; first_chk = 1; first_wr = cmd_write;
          cur_addr = cmd_addr; cur_data = cmd_wdata; cur_strb = cmd_wstrb;
          aw_hs = 0; w_hs = 0; ar_hs = 0;
        end
        p_awvalid = awvalid; p_awready = awready; p_awaddr = awaddr;
        p_wvalid = wvalid; p_wready = wready; p_wdata = wdata; p_wstrb = wstrb;
        p_arvalid = arvalid; p_arready = arready; p_araddr = araddr;
        p_bready = bready; p_bvalid = bvalid; p_rready = rready; p_rvalid = rvalid;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_cmd(input logic wr, input logic [3:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int lat, output logic [31:0] rd,
                        output logic [1:0] rs);
    push_expect(wr, a, d, s);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("rsp_arrives", rsp_valid, 1'b1);
    rd = rsp_rdata;
    rs = rsp_resp;
    @(posedge clk); #1;
  endtask

  int          lat, a0, w0, r0;
  logic [31:0] rd;
  logic [1:0]  rs;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    for (int i = 0; i < 4; i++) mmem[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 6'b0);
    check("rst_data", {awaddr, araddr, wstrb, wdata, rsp_rdata, rsp_resp}, 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // zero-wait write, read back, partial-strobe write, read back
    do_cmd(1'b1, 4'h4, 32'hDEADBEEF, 4'hF, lat, rd, rs);
    check("wr1_lat", lat, 3); check("wr1_resp", rs, 2'b00); check("wr1_rdata", rd, 32'h0);
    do_cmd(1'b0, 4'h4, 32'h0, 4'h0, lat, rd, rs);
    check("rd1_lat", lat, 3); check("rd1_rdata", rd, 32'hDEADBEEF);
    do_cmd(1'b1, 4'h4, 32'h0000CAFE, 4'h3, lat, rd, rs);
    check("wr2_lat", lat, 3);
    do_cmd(1'b0, 4'h4, 32'h0, 4'h0, lat, rd, rs);
    check("rd2_rdata", rd, 32'hDEADCAFE);

    // awready stalled three cycles, wready immediate
    aw_stall = 3; a0 = aw_hi; w0 = w_hi; r0 = rsp_seen;
    do_cmd(1'b1, 4'h8, 32'h12345678, 4'hF, lat, rd, rs);
    aw_stall = 0;
    check("awstall_aw_cycles", aw_hi - a0, 4);
    check("awstall_w_cycles", w_hi - w0, 1);
    check("awstall_rsp_count", rsp_seen - r0, 1);
    check("awstall_lat", lat, 6);

    // wready stalled two cycles, awready immediate (reverse order)
    w_stall = 2; a0 = aw_hi; w0 = w_hi;
    do_cmd(1'b1, 4'hC, 32'h0BADF00D, 4'hF, lat, rd, rs);
    w_stall = 0;
    check("wstall_aw_cycles", aw_hi - a0, 1);
    check("wstall_w_cycles", w_hi - w0, 3);
    check("wstall_lat", lat, 5);
    do_cmd(1'b0, 4'hC, 32'h0, 4'h0, lat, rd, rs);
    check("rd3_rdata", rd, 32'h0BADF00D);

    // arready stalled two cycles
    ar_stall = 2;
    do_cmd(1'b0, 4'h8, 32'h0, 4'h0, lat, rd, rs);
    ar_stall = 0;
    check("arstall_lat", lat, 5); check("arstall_rdata", rd, 32'h12345678);

    // error responses pass through
    bresp_code = SLVERR;
    do_cmd(1'b1, 4'h0, 32'h11111111, 4'hF, lat, rd, rs);
    bresp_code = OKAY;
    check("bresp_slverr", rs, 2'b10);
    rresp_code = DECERR;
    do_cmd(1'b0, 4'h4, 32'h0, 4'h0, lat, rd, rs);
    rresp_code = OKAY;
    check("rresp_decerr", rs, 2'b11); check("rresp_rdata", rd, 32'hDEADCAFE);

    // reset while waiting for the write response
    b_block = 1'b1;
    push_expect(1'b1, 4'hC, 32'hAAAA5555, 4'hF);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'hC; cmd_wdata = 32'hAAAA5555; cmd_wstrb = 4'hF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("wresp_bready", bready, 1'b1);
    check("wresp_no_bvalid", bvalid, 1'b0);
    r0 = rsp_seen;
    #2 rst = 1'b1;
    #1;
    check("midrst_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 6'b0);
    check("midrst_cmd_ready", cmd_ready, 1'b1);
    check("midrst_data", {awaddr, wdata, rsp_resp}, 64'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    b_block = 1'b0;
    @(posedge clk); #1;
    check("midrst_no_rsp", rsp_seen - r0, 0);
    do_cmd(1'b0, 4'h4, 32'h0, 4'h0, lat, rd, rs);
    check("postrst_lat", lat, 3); check("postrst_rdata", rd, 32'hDEADCAFE);

    repeat (2) @(posedge clk);
    check("all_rsp_consumed", exp_rd, exp_rdata.size());
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
